// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: default widths, NOP encoding,
// fetch FSM state type and a saturating counter helper.
package cpu_pkg;
    localparam int          PC_W_DEF    = 8;
    localparam int          INSTR_W_DEF = 32;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } fetch_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
endpackage

// File: rtl/instr_fetch_stage_pc_reg.sv
// fetch_pc_reg: program counter register with next-PC selection
// (reset > redirect load > sequential increment > hold).
module fetch_pc_reg
    import cpu_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_load,
    input  logic [PC_W-1:0] i_load_pc,
    input  logic            i_advance,
    output logic [PC_W-1:0] o_pc,
    output logic [PC_W-1:0] o_pc_inc
);
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_pc_next;

    // Wraps modulo 2^PC_W by construction.
    assign w_pc_inc = r_pc + PC_W'(PC_STEP);

    always_comb begin
        w_pc_next = r_pc;
        if (i_load) begin
            w_pc_next = i_load_pc;
        end else if (i_advance) begin
            w_pc_next = w_pc_inc;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc     = r_pc;
    assign o_pc_inc = w_pc_inc;
endmodule

// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: IF stage with fetch FSM and IF/ID latch.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/stall/flush counters.
//   state  | meaning
//   S_BOOT | one dead cycle after reset, no memory read
//   S_RUN  | fetching; redirect > stall > halt > sequential
//   S_HALT | fetch stopped while halt is high, IF/ID held invalid
module instr_fetch_stage
    import cpu_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter int              INSTR_W  = INSTR_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_stall,
    input  logic               i_redirect,
    input  logic [PC_W-1:0]    i_redirect_pc,
    input  logic               i_halt,
    output logic [PC_W-1:0]    o_imem_addr,
    output logic               o_imem_read,
    input  logic [INSTR_W-1:0] i_imem_data,
    output logic [INSTR_W-1:0] o_if_id_instr,
    output logic [PC_W-1:0]    o_if_id_pc4,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0]        o_perf_fetch,
    output logic [15:0]        o_perf_stall,
    output logic [15:0]        o_perf_flush,
`endif
    output logic               o_if_id_valid
);
    fetch_state_t       r_state;
    fetch_state_t       w_state_next;
    logic               w_imem_read;
    logic               w_latch;
    logic               w_flush;
    logic               w_count_stall;
    logic [PC_W-1:0]    w_pc;
    logic [PC_W-1:0]    w_pc_inc;
    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_pc4;
    logic               r_valid;

    fetch_pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_reg (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_load    (i_redirect),
        .i_load_pc (i_redirect_pc),
        .i_advance (w_latch),
        .o_pc      (w_pc),
        .o_pc_inc  (w_pc_inc)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_imem_read   = 1'b0;
        w_latch       = 1'b0;
        w_flush       = 1'b0;
        w_count_stall = 1'b0;
        case (r_state)
            S_BOOT: begin
                w_flush      = 1'b1;
                w_state_next = S_RUN;
            end
            S_RUN: begin
                w_imem_read = 1'b1;
                if (i_redirect) begin
                    w_flush = 1'b1;
                end else if (i_stall) begin
                    w_count_stall = 1'b1;
                end else if (i_halt) begin
                    w_flush      = 1'b1;
                    w_state_next = S_HALT;
                end else begin
                    w_latch = 1'b1;
                end
            end
            S_HALT: begin
                w_flush = 1'b1;
                if (!i_halt) begin
                    w_state_next = S_RUN;
                end
            end
            default: begin
                w_flush      = 1'b1;
                w_state_next = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_instr <= INSTR_W'(NOP_INSTR);
            r_pc4   <= '0;
            r_valid <= 1'b0;
        end else if (w_latch) begin
            r_instr <= i_imem_data;
            r_pc4   <= w_pc_inc;
            r_valid <= 1'b1;
        end else if (w_flush) begin
            r_instr <= INSTR_W'(NOP_INSTR);
            r_pc4   <= '0;
            r_valid <= 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_perf_fetch;
    logic [15:0] r_perf_stall;
    logic [15:0] r_perf_flush;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_perf_fetch <= '0;
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if (w_latch)       r_perf_fetch <= sat_inc16(r_perf_fetch);
            if (w_count_stall) r_perf_stall <= sat_inc16(r_perf_stall);
            if (i_redirect)    r_perf_flush <= sat_inc16(r_perf_flush);
        end
    end

    assign o_perf_fetch = r_perf_fetch;
    assign o_perf_stall = r_perf_stall;
    assign o_perf_flush = r_perf_flush;
`endif

    assign o_imem_addr   = w_pc;
    assign o_imem_read   = w_imem_read;
    assign o_if_id_instr = r_instr;
    assign o_if_id_pc4   = r_pc4;
    assign o_if_id_valid = r_valid;
endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: directed scenarios plus
// randomized traffic compared against a behavioural fetch model.
module tb_instr_fetch_stage;
    localparam int MODE_BOOT = 0;
    localparam int MODE_RUN  = 1;
    localparam int MODE_HALT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_pc = 8'h00;
    logic        halt = 1'b0;
    logic [7:0]  imem_addr;
    logic        imem_read;
    logic [31:0] imem_data;
    logic [31:0] if_id_instr;
    logic [7:0]  if_id_pc4;
    logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_fetch;
    logic [15:0] perf_stall;
    logic [15:0] perf_flush;
`endif

    logic [31:0] mem [64];
    assign imem_data = mem[imem_addr[7:2]];

    int          n_checks = 0;
    int          n_errors = 0;

    // Reference model state
    int          m_mode;
    logic [7:0]  m_pc;
    logic [31:0] m_instr;
    logic [7:0]  m_pc4;
    logic        m_valid;
    logic [15:0] m_fetch, m_stall, m_flush;

    always #5 clk = ~clk;

    instr_fetch_stage dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_stall       (stall),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .i_halt        (halt),
        .o_imem_addr   (imem_addr),
        .o_imem_read   (imem_read),
        .i_imem_data   (imem_data),
        .o_if_id_instr (if_id_instr),
        .o_if_id_pc4   (if_id_pc4),
`ifdef FETCH_PERF_CNT_EN
        .o_perf_fetch  (perf_fetch),
        .o_perf_stall  (perf_stall),
        .o_perf_flush  (perf_flush),
`endif
        .o_if_id_valid (if_id_valid)
    );

    function automatic logic [15:0] sat(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // One rising edge: model applies the fetch rules to the inputs seen at
    // the edge, then outputs are left to settle before the caller compares.
    task automatic step();
        logic [7:0] inc;
        @(posedge clk);
        inc = m_pc + 8'd4;
        if (rst) begin
            m_mode = MODE_BOOT; m_pc = 8'h00; m_instr = 32'h0; m_pc4 = 8'h00; m_valid = 1'b0;
            m_fetch = 16'h0; m_stall = 16'h0; m_flush = 16'h0;
        end else begin
            if (redirect) m_flush = sat(m_flush);
            if (m_mode == MODE_BOOT) begin
                if (redirect) m_pc = redirect_pc;
                m_mode = MODE_RUN;
            end else if (m_mode == MODE_RUN) begin
                if (redirect) begin
                    m_pc = redirect_pc; m_instr = 32'h0; m_valid = 1'b0;
                end else if (stall) begin
                    m_stall = sat(m_stall);
                end else if (halt) begin
                    m_instr = 32'h0; m_valid = 1'b0; m_mode = MODE_HALT;
                end else begin
                    m_instr = mem[m_pc[7:2]]; m_pc4 = inc; m_pc = inc; m_valid = 1'b1;
                    m_fetch = sat(m_fetch);
                end
            end else begin
                if (redirect) m_pc = redirect_pc;
                if (!halt) m_mode = MODE_RUN;
            end
        end
        #1;
    endtask

    task automatic drive(input logic r, input logic s, input logic rd, input logic [7:0] rpc, input logic h);
        rst = r; stall = s; redirect = rd; redirect_pc = rpc; halt = h;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (imem_addr !== 8'h00 || imem_read !== 1'b0 || if_id_valid !== 1'b0 ||
                if_id_instr !== 32'h0 || if_id_pc4 !== 8'h00) begin
                n_errors++;
                $display("FAIL reset_state: addr=%h read=%b valid=%b instr=%h pc4=%h, want 00 0 0 00000000 00",
                         imem_addr, imem_read, if_id_valid, if_id_instr, if_id_pc4);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step();
        n_checks++;
        if (if_id_valid !== 1'b0 || imem_addr !== 8'h00 || imem_read !== 1'b1) begin
            n_errors++;
            $display("FAIL boot_dead_cycle: valid=%b addr=%h read=%b, want 0 00 1", if_id_valid, imem_addr, imem_read);
        end
        step();
        n_checks++;
        if (if_id_valid !== 1'b1 || if_id_instr !== 32'h20030009 || if_id_pc4 !== 8'h04 || imem_addr !== 8'h04) begin
            n_errors++;
            $display("FAIL first_fetch: valid=%b instr=%h pc4=%h addr=%h, want 1 20030009 04 04",
                     if_id_valid, if_id_instr, if_id_pc4, imem_addr);
        end
        step();
        n_checks++;
        if (imem_addr !== 8'h08 || if_id_instr !== mem[1] || if_id_pc4 !== 8'h08) begin
            n_errors++;
            $display("FAIL second_fetch: addr=%h instr=%h pc4=%h, want 08 %h 08", imem_addr, if_id_instr, if_id_pc4, mem[1]);
        end
    endtask

    task automatic test_stall();
        drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (imem_addr !== 8'h08 || if_id_instr !== mem[1] || if_id_pc4 !== 8'h08 || if_id_valid !== 1'b1) begin
                n_errors++;
                $display("FAIL stall_hold: addr=%h instr=%h pc4=%h valid=%b, want 08 %h 08 1",
                         imem_addr, if_id_instr, if_id_pc4, if_id_valid, mem[1]);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step();
        n_checks++;
        if (imem_addr !== 8'h0C || if_id_instr !== mem[2]) begin
            n_errors++;
            $display("FAIL stall_release: addr=%h instr=%h, want 0c %h", imem_addr, if_id_instr, mem[2]);
        end
    endtask

    task automatic test_redirect_stall();
        drive(1'b0, 1'b1, 1'b1, 8'h20, 1'b0);
        step();
        n_checks++;
        if (imem_addr !== 8'h20 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin
            n_errors++;
            $display("FAIL redirect_flush: addr=%h valid=%b instr=%h, want 20 0 00000000", imem_addr, if_id_valid, if_id_instr);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step();
        n_checks++;
        if (if_id_instr !== mem[8] || if_id_valid !== 1'b1 || if_id_pc4 !== 8'h24 || imem_addr !== 8'h24) begin
            n_errors++;
            $display("FAIL redirect_target_fetch: instr=%h valid=%b pc4=%h addr=%h, want %h 1 24 24",
                     if_id_instr, if_id_valid, if_id_pc4, imem_addr, mem[8]);
        end
    endtask

    task automatic test_wrap();
        drive(1'b0, 1'b0, 1'b1, 8'hFC, 1'b0);
        step();
        n_checks++;
        if (imem_addr !== 8'hFC) begin
            n_errors++;
            $display("FAIL wrap_load: addr=%h, want fc", imem_addr);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step();
        n_checks++;
        if (imem_addr !== 8'h00 || if_id_pc4 !== 8'h00 || if_id_instr !== mem[63] || if_id_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL wrap_fetch: addr=%h pc4=%h instr=%h valid=%b, want 00 00 %h 1",
                     imem_addr, if_id_pc4, if_id_instr, if_id_valid, mem[63]);
        end
    endtask

    task automatic test_halt();
        logic [7:0] held;
        held = imem_addr;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (imem_read !== 1'b0 || imem_addr !== held || if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin
                n_errors++;
                $display("FAIL halt_hold: read=%b addr=%h valid=%b instr=%h, want 0 %h 0 00000000",
                         imem_read, imem_addr, if_id_valid, if_id_instr, held);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step();
        n_checks++;
        if (imem_read !== 1'b1 || imem_addr !== held || if_id_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL halt_exit: read=%b addr=%h valid=%b, want 1 %h 0", imem_read, imem_addr, if_id_valid, held);
        end
        step();
        n_checks++;
        if (if_id_valid !== 1'b1 || if_id_instr !== mem[held[7:2]] || imem_addr !== held + 8'd4) begin
            n_errors++;
            $display("FAIL halt_resume: valid=%b instr=%h addr=%h, want 1 %h %h",
                     if_id_valid, if_id_instr, imem_addr, mem[held[7:2]], held + 8'd4);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < 10),
                  8'($urandom_range(0, 255)), ($urandom_range(0, 99) < 12));
            step();
            n_checks++;
            if (imem_addr !== m_pc || imem_read !== (m_mode == MODE_RUN) || if_id_valid !== m_valid ||
                if_id_instr !== m_instr || (m_valid && if_id_pc4 !== m_pc4)) begin
                n_errors++;
                $display("FAIL random_cycle %0d: addr=%h read=%b valid=%b instr=%h pc4=%h, want %h %b %b %h %h",
                         i, imem_addr, imem_read, if_id_valid, if_id_instr, if_id_pc4,
                         m_pc, (m_mode == MODE_RUN), m_valid, m_instr, m_pc4);
            end
`ifdef FETCH_PERF_CNT_EN
            n_checks++;
            if (perf_fetch !== m_fetch || perf_stall !== m_stall || perf_flush !== m_flush) begin
                n_errors++;
                $display("FAIL random_perf %0d: fetch=%0d stall=%0d flush=%0d, want %0d %0d %0d",
                         i, perf_fetch, perf_stall, perf_flush, m_fetch, m_stall, m_flush);
            end
`endif
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) step();
`ifdef FETCH_PERF_CNT_EN
        n_checks++;
        if (perf_fetch !== m_fetch || perf_stall !== m_stall || perf_flush !== m_flush) begin
            n_errors++;
            $display("FAIL perf_before_reset: fetch=%0d stall=%0d flush=%0d, want %0d %0d %0d",
                     perf_fetch, perf_stall, perf_flush, m_fetch, m_stall, m_flush);
        end
`endif
        drive(1'b1, 1'b1, 1'b1, 8'h40, 1'b1);
        step();
        n_checks++;
        if (imem_addr !== 8'h00 || imem_read !== 1'b0 || if_id_valid !== 1'b0 ||
            if_id_instr !== 32'h0 || if_id_pc4 !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_mid_run: addr=%h read=%b valid=%b instr=%h pc4=%h, want 00 0 0 00000000 00",
                     imem_addr, imem_read, if_id_valid, if_id_instr, if_id_pc4);
        end
`ifdef FETCH_PERF_CNT_EN
        n_checks++;
        if (perf_fetch !== 16'h0 || perf_stall !== 16'h0 || perf_flush !== 16'h0) begin
            n_errors++;
            $display("FAIL perf_reset: fetch=%0d stall=%0d flush=%0d, want 0 0 0", perf_fetch, perf_stall, perf_flush);
        end
`endif
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h20030009;
        m_mode = MODE_BOOT; m_pc = 8'h00; m_instr = 32'h0; m_pc4 = 8'h00; m_valid = 1'b0;
        m_fetch = 16'h0; m_stall = 16'h0; m_flush = 16'h0;
        test_reset();
        test_stall();
        test_redirect_stall();
        test_wrap();
        test_halt();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
